// File: rtl/video_pkg.sv
// Shared constants and types for the soc_video CPU-port front end.
package video_pkg;

  localparam logic [23:0] DEF_TEXT_BASE  = 24'hF00000;
  localparam int unsigned DEF_TEXT_BYTES = 2048;
  localparam logic [23:0] PALETTE_BASE   = 24'hE00000;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

endpackage

// File: rtl/video_byte_mask.sv
// Byte-lane strobe for one fill word: clips the lanes below the start byte on
// the first word and the lanes above the end byte on the last word.
module video_byte_mask (
  input  logic       first_i,
  input  logic       last_i,
  input  logic [1:0] a_lo_i,
  input  logic [1:0] e_lo_i,
  output logic [3:0] wren_o
);

  logic [3:0] first_mask;
  logic [3:0] last_mask;

  always_comb begin
    first_mask = first_i ? (4'b1111 << a_lo_i) : 4'b1111;
    last_mask  = last_i  ? (4'b1111 >> (2'd3 - e_lo_i)) : 4'b1111;
    wren_o     = first_mask & last_mask;
  end

endmodule

// File: rtl/video_fill_ctrl.sv
// Shares the soc_video CPU port between the CPU and a text-RAM fill engine
// that writes a byte value over a byte range using strobed word writes.
module video_fill_ctrl
  import video_pkg::*;
#(
  parameter logic [23:0] TEXT_BASE  = DEF_TEXT_BASE,
  parameter int unsigned TEXT_BYTES = DEF_TEXT_BYTES,
  parameter int unsigned MAX_STALL  = 4
) (
  input  logic        clk_cpu,
  input  logic        n_reset,
  input  logic        cpu_sel,
  input  logic [3:0]  cpu_wren,
  input  logic [23:0] cpu_address,
  input  logic [31:0] cpu_data_in,
  output logic [31:0] cpu_data_out,
  output logic        cpu_ready,
  input  logic        fill_start,
  input  logic [7:0]  fill_byte,
  input  logic [10:0] fill_offset,
  input  logic [11:0] fill_len,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        vid_sel,
  output logic [3:0]  vid_wren,
  output logic [23:0] vid_address,
  output logic [31:0] vid_data_in,
  input  logic [31:0] vid_data_out
);

  localparam int unsigned SW         = $clog2(MAX_STALL + 1);
  localparam logic [12:0] TEXT_LIMIT = 13'(TEXT_BYTES);

  fill_state_t   state_q, state_d;
  logic [8:0]    w_q, w_d;
  logic [10:0]   e_q, e_d;
  logic [1:0]    a_lo_q, a_lo_d;
  logic          first_q, first_d;
  logic [7:0]    byte_q, byte_d;
  logic [SW-1:0] stall_q, stall_d;

  logic [12:0] end_sum;
  logic [12:0] end_excl;
  logic [10:0] end_idx;
  logic        last_word;
  logic        stall_full;
  logic        in_fill;
  logic        cpu_win;
  logic        eng_wr;
  logic [3:0]  eng_wren;

  // End index is clipped to the top of text RAM so the engine never wraps.
  always_comb begin
    end_sum  = {2'b00, fill_offset} + {1'b0, fill_len};
    end_excl = (end_sum > TEXT_LIMIT) ? TEXT_LIMIT : end_sum;
    end_idx  = 11'(end_excl - 13'd1);
  end

  assign last_word  = (w_q == e_q[10:2]);
  assign stall_full = (stall_q == SW'(MAX_STALL));
  assign in_fill    = (state_q == FILL);
  assign cpu_win    = cpu_sel && !(in_fill && stall_full);
  assign eng_wr     = in_fill && !cpu_win;

  video_byte_mask u_mask (
    .first_i (first_q),
    .last_i  (last_word),
    .a_lo_i  (a_lo_q),
    .e_lo_i  (e_q[1:0]),
    .wren_o  (eng_wren)
  );

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fill_start) state_d = (fill_len == '0) ? DONE : FILL;
      FILL: if (eng_wr && last_word) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vid_sel     = 1'b0;
    vid_wren    = '0;
    vid_address = '0;
    vid_data_in = '0;
    cpu_ready   = 1'b0;
    if (eng_wr) begin
      vid_sel     = 1'b1;
      vid_wren    = eng_wren;
      vid_address = TEXT_BASE + 24'({w_q, 2'b00});
      vid_data_in = {4{byte_q}};
    end else if (cpu_win) begin
      vid_sel     = 1'b1;
      vid_wren    = cpu_wren;
      vid_address = cpu_address;
      vid_data_in = cpu_data_in;
      cpu_ready   = 1'b1;
    end
  end

  assign cpu_data_out = vid_data_out;
  assign fill_busy    = (state_q != IDLE);
  assign fill_done    = (state_q == DONE);

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      w_q     <= '0;
      e_q     <= '0;
      a_lo_q  <= '0;
      first_q <= 1'b0;
      byte_q  <= '0;
      stall_q <= '0;
    end else begin
      w_q     <= w_d;
      e_q     <= e_d;
      a_lo_q  <= a_lo_d;
      first_q <= first_d;
      byte_q  <= byte_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    w_d     = w_q;
    e_d     = e_q;
    a_lo_d  = a_lo_q;
    first_d = first_q;
    byte_d  = byte_q;
    stall_d = '0;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          byte_d  = fill_byte;
          a_lo_d  = fill_offset[1:0];
          e_d     = end_idx;
          w_d     = fill_offset[10:2];
          first_d = 1'b1;
        end
      end
      FILL: begin
        if (eng_wr) begin
          w_d     = w_q + 9'd1;
          first_d = 1'b0;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_video_fill_ctrl.sv
// Self-checking bench for video_fill_ctrl: directed fill scenarios plus
// randomized traffic against a byte-range/write-queue reference model.
module tb_video_fill_ctrl;

  localparam int unsigned MAX_STALL = 4;

  logic        clk_cpu = 1'b0;
  logic        n_reset;
  logic        cpu_sel;
  logic [3:0]  cpu_wren;
  logic [23:0] cpu_address;
  logic [31:0] cpu_data_in;
  logic [31:0] cpu_data_out;
  logic        cpu_ready;
  logic        fill_start;
  logic [7:0]  fill_byte;
  logic [10:0] fill_offset;
  logic [11:0] fill_len;
  logic        fill_busy;
  logic        fill_done;
  logic        vid_sel;
  logic [3:0]  vid_wren;
  logic [23:0] vid_address;
  logic [31:0] vid_data_in;
  logic [31:0] vid_data_out;

  always #5 clk_cpu = ~clk_cpu;

  video_fill_ctrl #(
    .TEXT_BASE  (24'hF00000),
    .TEXT_BYTES (2048),
    .MAX_STALL  (MAX_STALL)
  ) dut (
    .clk_cpu      (clk_cpu),
    .n_reset      (n_reset),
    .cpu_sel      (cpu_sel),
    .cpu_wren     (cpu_wren),
    .cpu_address  (cpu_address),
    .cpu_data_in  (cpu_data_in),
    .cpu_data_out (cpu_data_out),
    .cpu_ready    (cpu_ready),
    .fill_start   (fill_start),
    .fill_byte    (fill_byte),
    .fill_offset  (fill_offset),
    .fill_len     (fill_len),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .vid_sel      (vid_sel),
    .vid_wren     (vid_wren),
    .vid_address  (vid_address),
    .vid_data_in  (vid_data_in),
    .vid_data_out (vid_data_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending engine writes as a queue derived byte by byte.
  int unsigned q_addr[$];
  logic [3:0]  q_wren[$];
  bit          m_done;
  int unsigned m_stall;
  logic [7:0]  m_byte;

  task automatic model_reset();
    q_addr.delete();
    q_wren.delete();
    m_done  = 1'b0;
    m_stall = 0;
  endtask

  task automatic model_start(input int unsigned off, input int unsigned len, input logic [7:0] b);
    int unsigned stop;
    int unsigned addr;
    logic [3:0]  t;
    m_byte = b;
    stop   = off + len;
    if (stop > 2048) stop = 2048;
    if (len == 0) begin
      m_done = 1'b1;
    end else begin
      for (int unsigned i = off; i < stop; i++) begin
        addr = 32'hF00000 + (i / 4) * 4;
        if (q_addr.size() == 0 || q_addr[q_addr.size()-1] != addr) begin
          q_addr.push_back(addr);
          q_wren.push_back(4'b0000);
        end
        t = q_wren[q_wren.size()-1];
        t[i % 4] = 1'b1;
        q_wren[q_wren.size()-1] = t;
      end
    end
  endtask

  bit          o_eng, o_done, o_ready;
  logic [23:0] o_addr;
  logic [3:0]  o_wren;

  task automatic step();
    bit          cpu_gets, eng, busy;
    logic        es, er;
    logic [3:0]  ew;
    logic [23:0] ea;
    logic [31:0] ed;
    @(negedge clk_cpu);
    if (!n_reset) model_reset();
    busy     = m_done || (q_addr.size() > 0);
    cpu_gets = cpu_sel && !((q_addr.size() > 0) && (m_stall >= MAX_STALL));
    eng      = (q_addr.size() > 0) && !cpu_gets;
    es = 1'b0; er = 1'b0; ew = '0; ea = '0; ed = '0;
    if (eng) begin
      es = 1'b1; ew = q_wren[0]; ea = 24'(q_addr[0]); ed = {4{m_byte}};
    end else if (cpu_gets) begin
      es = 1'b1; er = 1'b1; ew = cpu_wren; ea = cpu_address; ed = cpu_data_in;
    end
    check_eq("vid_sel",      32'(vid_sel),     32'(es));
    check_eq("vid_wren",     32'(vid_wren),    32'(ew));
    check_eq("vid_address",  32'(vid_address), 32'(ea));
    check_eq("vid_data_in",  vid_data_in,      ed);
    check_eq("cpu_ready",    32'(cpu_ready),   32'(er));
    check_eq("cpu_data_out", cpu_data_out,     vid_data_out);
    check_eq("fill_busy",    32'(fill_busy),   32'(busy));
    check_eq("fill_done",    32'(fill_done),   32'(m_done));
    o_eng   = vid_sel && !cpu_ready;
    o_done  = fill_done;
    o_ready = cpu_ready;
    o_addr  = vid_address;
    o_wren  = vid_wren;
    if (n_reset) begin
      if (m_done) begin
        m_done  = 1'b0;
        m_stall = 0;
      end else if (q_addr.size() > 0) begin
        if (eng) begin
          void'(q_addr.pop_front());
          void'(q_wren.pop_front());
          m_stall = 0;
          if (q_addr.size() == 0) m_done = 1'b1;
        end else begin
          m_stall++;
        end
      end else begin
        m_stall = 0;
        if (fill_start) model_start(int'(fill_offset), int'(fill_len), fill_byte);
      end
    end
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic rand_cpu(input bit hold, input int unsigned pct);
    cpu_sel      = hold ? 1'b1 : ($urandom_range(0, 99) < pct);
    cpu_wren     = 4'($urandom);
    cpu_address  = 24'($urandom);
    cpu_data_in  = $urandom;
    vid_data_out = $urandom;
  endtask

  logic [23:0] s_addr[$];
  logic [3:0]  s_wren[$];
  int          s_cyc[$];
  int          done_cyc;
  int          ready_cnt;

  task automatic run_fill(input int unsigned off, input int unsigned len, input logic [7:0] b,
                          input bit hold, input int restart_at);
    s_addr.delete(); s_wren.delete(); s_cyc.delete();
    done_cyc  = -1;
    ready_cnt = 0;
    fill_offset = 11'(off);
    fill_len    = 12'(len);
    fill_byte   = b;
    fill_start  = 1'b1;
    rand_cpu(hold, 0);
    step();
    for (int c = 1; c <= 2000; c++) begin
      rand_cpu(hold, 0);
      if (c == restart_at) begin
        fill_start = 1'b1; fill_offset = 11'd100; fill_len = 12'd40; fill_byte = 8'hAA;
      end else begin
        fill_start = 1'b0;
      end
      step();
      if (o_done) begin
        done_cyc = c;
        break;
      end
      if (o_ready) ready_cnt++;
      if (o_eng) begin
        s_addr.push_back(o_addr);
        s_wren.push_back(o_wren);
        s_cyc.push_back(c);
      end
    end
    fill_start = 1'b0;
    check_eq("fill_finished", 32'(done_cyc > 0), 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_reset = 1'b0; cpu_sel = 1'b0; cpu_wren = '0; cpu_address = '0; cpu_data_in = '0;
    vid_data_out = '0; fill_start = 1'b0; fill_byte = '0; fill_offset = '0; fill_len = '0;
    model_reset();
    step();
    step();
    n_reset = 1'b1;
    step();

    run_fill(0, 8, 8'h20, 1'b0, 0);
    check_eq("t1_nwr", 32'(s_addr.size()), 32'd2);
    if (s_addr.size() == 2) begin
      check_eq("t1_a0", 32'(s_addr[0]), 32'hF00000);
      check_eq("t1_w0", 32'(s_wren[0]), 32'hF);
      check_eq("t1_c0", 32'(s_cyc[0]),  32'd1);
      check_eq("t1_a1", 32'(s_addr[1]), 32'hF00004);
      check_eq("t1_w1", 32'(s_wren[1]), 32'hF);
    end
    check_eq("t1_done", 32'(done_cyc), 32'd3);

    run_fill(1, 6, 8'h41, 1'b0, 0);
    check_eq("t2_nwr", 32'(s_addr.size()), 32'd2);
    if (s_addr.size() == 2) begin
      check_eq("t2_a0", 32'(s_addr[0]), 32'hF00000);
      check_eq("t2_w0", 32'(s_wren[0]), 32'b1110);
      check_eq("t2_a1", 32'(s_addr[1]), 32'hF00004);
      check_eq("t2_w1", 32'(s_wren[1]), 32'b0111);
    end

    run_fill(5, 2, 8'h7E, 1'b0, 0);
    check_eq("t3_nwr", 32'(s_addr.size()), 32'd1);
    if (s_addr.size() == 1) begin
      check_eq("t3_a0", 32'(s_addr[0]), 32'hF00004);
      check_eq("t3_w0", 32'(s_wren[0]), 32'b0110);
    end
    check_eq("t3_done", 32'(done_cyc), 32'd2);

    run_fill(2046, 10, 8'h33, 1'b0, 0);
    check_eq("clip_nwr", 32'(s_addr.size()), 32'd1);
    if (s_addr.size() == 1) begin
      check_eq("clip_a0", 32'(s_addr[0]), 32'hF007FC);
      check_eq("clip_w0", 32'(s_wren[0]), 32'b1100);
    end

    run_fill(0, 4, 8'h11, 1'b1, 0);
    check_eq("hold_ready", 32'(ready_cnt), 32'd4);
    check_eq("hold_nwr",   32'(s_addr.size()), 32'd1);
    if (s_addr.size() == 1) begin
      check_eq("hold_cyc", 32'(s_cyc[0]),  32'd5);
      check_eq("hold_a0",  32'(s_addr[0]), 32'hF00000);
    end
    check_eq("hold_done", 32'(done_cyc), 32'd6);

    run_fill(300, 0, 8'h99, 1'b0, 0);
    check_eq("len0_done", 32'(done_cyc), 32'd1);
    check_eq("len0_nwr",  32'(s_addr.size()), 32'd0);

    run_fill(0, 8, 8'h55, 1'b0, 1);
    check_eq("restart_nwr",  32'(s_addr.size()), 32'd2);
    check_eq("restart_done", 32'(done_cyc), 32'd3);

    // Abort mid-fill with an asynchronous reset.
    rand_cpu(1'b0, 0);
    fill_offset = 11'd0; fill_len = 12'd64; fill_byte = 8'hC3; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #2 n_reset = 1'b0;
    #1;
    check_eq("rst_busy", 32'(fill_busy), 32'd0);
    check_eq("rst_done", 32'(fill_done), 32'd0);
    model_reset();
    step();
    n_reset = 1'b1;
    for (int i = 0; i < 5; i++) step();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      int unsigned r;
      rand_cpu(1'b0, 35);
      fill_start  = ($urandom_range(0, 19) == 0);
      fill_byte   = 8'($urandom);
      fill_offset = 11'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        fill_len = 12'd0;
      end else if (r == 1) begin
        fill_len = 12'($urandom_range(0, 2048));
      end else if (r == 2) begin
        fill_offset = 11'(2048 - $urandom_range(1, 8));
        fill_len    = 12'($urandom_range(1, 20));
      end else begin
        fill_len = 12'($urandom_range(1, 24));
      end
      n_reset = ($urandom_range(0, 999) != 0);
      step();
      n_reset = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
